sort_controller: RTL
====================

// Module: sort_controller
// PURPOSE
// - Buffers a burst of DEPTH unsigned words, sorts them ascending with one shared greater-than comparator, then streams them out.
// - Performs one compare-and-swap per cycle (bubble sort).
// - Sits between a producer and a consumer, both using valid/ready.
// - Sequences the team's 4-bit magnitude comparison as a time-multiplexed resource.
// PARAMETERS
// - WIDTH  4  data word width, unsigned
// - DEPTH  8  words per burst; DEPTH >= 2; index counters are $clog2(DEPTH) bits
// PORTS
// - clk        in   1      single clock; all state updates on posedge clk
// - reset      in   1      synchronous, active-high reset
// - in_valid   in   1      producer has in_data
// - in_ready   out  1      controller accepts in_data (LOAD state only)
// - in_data    in   WIDTH  input word
// - out_valid  out  1      out_data holds a sorted word (DRAIN state only)
// - out_ready  in   1      consumer accepts out_data
// - out_data   out  WIDTH  sorted output word; 0 when out_valid=0
// - busy       out  1      high while in SORT
// BEHAVIOUR
// - Reset values
//   - state=LOAD, all indices=0.
//   - in_ready=1, out_valid=0, out_data=0, busy=0.
//   - Buffer contents are not cleared and are don't-care.
// - Reset mid-operation
//   - Reset wins over every other event in that cycle.
//   - It abandons the burst from any state.
//   - The cycle after reset deasserts, LOAD accepts a fresh burst.
// - LOAD
//   - in_ready=1.
//   - On in_valid&&in_ready: mem[wr_idx]<=in_data, wr_idx++.
//   - The DEPTH-th accept sets wr_idx=0 and moves to SORT on the next cycle.
// - SORT
//   - busy=1; in_ready=0, so in_valid is ignored.
//   - Each cycle compares mem[j] and mem[j+1] for j=0..DEPTH-2.
//   - If mem[j] > mem[j+1] (unsigned, strict), the two entries swap in that same cycle.
//   - Equal values never swap, so the sort is stable.
//   - After j=DEPTH-2, j wraps to 0 and the pass counter increments.
//   - Exactly DEPTH-1 passes of DEPTH-1 compares, so SORT lasts (DEPTH-1)^2 cycles.
//   - After the last compare, the next state is DRAIN.
// - DRAIN
//   - out_valid=1, out_data=mem[rd_idx], in_ready=0.
//   - rd_idx++ on out_valid&&out_ready.
//   - While out_ready=0, out_data is held stable.
//   - After the DEPTH-th transfer: rd_idx=0, state=LOAD.
//   - LOAD is entered on the next cycle; the first new word can be accepted that cycle.
// - Outputs are registered-state decodes; there is no combinational path from in_valid or out_ready to outputs.
// - Throughput per burst: DEPTH load cycles + SORT cycles + DEPTH drain cycles (with no stalls).
// CONFIGURATION
// - SORT_EARLY_EXIT_EN defined
//   - A per-pass swap flag clears at the start of each pass.
//   - If a pass completes with no swap, the next state is DRAIN immediately.
//   - SORT length = passes_run*(DEPTH-1) cycles; minimum DEPTH-1 for already-sorted input.
//   - The final pass limit of DEPTH-1 still applies.
// - SORT_EARLY_EXIT_EN not defined
//   - Fixed (DEPTH-1)^2-cycle SORT regardless of data.
//   - Output data is identical in both builds.
// TESTING (WIDTH=4, DEPTH=8)
// - Reverse input 7,6,5,4,3,2,1,0 -> out 0..7; busy high exactly 49 cycles in both builds.
// - Sorted input 0..7 -> out 0..7; busy 49 cycles without the macro, 7 cycles with SORT_EARLY_EXIT_EN.
// - Duplicates 5,3,5,0,15,3,0,15 -> out 0,0,3,3,5,5,15,15; 15>14-style unsigned edge gives no wrap error.
// - Backpressure: out_ready pattern 1,0,0,1,0,1... -> out_data stable while stalled; exactly 8 words, no drop or duplicate.
// - Reset asserted during SORT pass 3 -> next cycle in_ready=1, busy=0, out_valid=0; a new 8-word burst sorts correctly.
// - in_valid held high during SORT and DRAIN -> no extra accepts (in_ready=0); buffer unchanged by in_data.

Source files
------------

// File: rtl/sort_controller.sv
// -----------------------------------------------------------------------------
// sort_controller
//
// Buffers a burst of DEPTH unsigned words and sorts them ascending with a
// bubble sort. A single greater-than comparator is shared across the sort,
// and one compare-and-swap happens per cycle. The sorted words are then
// streamed out.
//
// Both the producer side and the consumer side use valid/ready handshakes.
//
// Phases: LOAD (accept DEPTH words) -> SORT -> DRAIN (emit DEPTH words).
//
// Optional build macro: SORT_EARLY_EXIT_EN
//   - When defined, SORT ends after the first pass that performs no swap.
//   - When undefined, SORT always runs for (DEPTH-1)^2 cycles.
//   - The sorted output is the same in both builds.
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous active-high reset
//   in_valid   in   1      producer has in_data
//   in_ready   out  1      accepting in_data (LOAD only)
//   in_data    in   WIDTH  input word
//   out_valid  out  1      out_data holds a sorted word (DRAIN only)
//   out_ready  in   1      consumer accepts out_data
//   out_data   out  WIDTH  sorted word, 0 when out_valid=0
//   busy       out  1      high while sorting
// -----------------------------------------------------------------------------
module sort_controller #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_J   = IW'(DEPTH - 2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    j;
  logic [IW-1:0]    pass;
  logic [IW-1:0]    j_next;
  logic             gt;

  // The shared comparator: one unsigned strict compare of the current pair.
  // Equal values never swap, which keeps the sort stable.
  assign j_next = j + 1'b1;
  assign gt     = mem[j] > mem[j_next];

`ifdef SORT_EARLY_EXIT_EN
  logic swapped;  // any swap seen so far in the current pass
`endif

  // ---------------------------------------------------------------------------
  // Control state: FSM and index counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      j      <= '0;
      pass   <= '0;
`ifdef SORT_EARLY_EXIT_EN
      swapped <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx <= '0;
              state  <= SORT;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end

        SORT: begin
          if (j == LAST_J) begin
            // End of a pass: wrap the compare index and decide whether to stop.
            j    <= '0;
            pass <= pass + 1'b1;
`ifdef SORT_EARLY_EXIT_EN
            swapped <= 1'b0;
            // Stop after the last allowed pass, or after a pass with no swap.
            // The final compare of the pass counts toward the swap check.
            if (pass == LAST_J || !(swapped || gt)) begin
              pass  <= '0;
              state <= DRAIN;
            end
`else
            if (pass == LAST_J) begin
              pass  <= '0;
              state <= DRAIN;
            end
`endif
          end else begin
            j <= j_next;
`ifdef SORT_EARLY_EXIT_EN
            swapped <= swapped | gt;
`endif
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              state  <= LOAD;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset branch. Its contents are don't-care after
  // reset, and leaving the reset out lets it map onto plain storage.
  // Writes are still gated by reset so that reset wins in its cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD && in_valid) begin
        mem[wr_idx] <= in_data;
      end else if (state == SORT && gt) begin
        mem[j]      <= mem[j_next];
        mem[j_next] <= mem[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Outputs are decoded from registered state only. No path runs from
  // in_valid or out_ready to any output.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == SORT);
  assign out_data  = (state == DRAIN) ? mem[rd_idx] : '0;

endmodule
